// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - shared AXI response/burst encodings, responder FSM states, LFSR step
package ysyx_24080006_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RESP
    } rsp_fsm_e;

    // Fibonacci step, taps 16,14,13,11 (bit 15 is tap 16)
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

endpackage

// File: rtl/ysyx_24080006_lfsr16.sv
// rtl/ysyx_24080006_lfsr16.sv - 16-bit Fibonacci LFSR used as a latency source
module ysyx_24080006_lfsr16
    import ysyx_24080006_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr16_next(q);
        end
    end

endmodule

// File: rtl/ysyx_24080006_axi_rom_slv.sv
// rtl/ysyx_24080006_axi_rom_slv.sv - AXI4 read-only word memory responder with injected latency
module ysyx_24080006_axi_rom_slv
    import ysyx_24080006_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter string       INIT_FILE   = "",
    parameter int          LAT_MODE    = 0,
    parameter int          FIXED_LAT   = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          ID_W        = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            arvalid,
    output logic            arready,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    output logic            rvalid,
    input  logic            rready,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic [ID_W-1:0] rid
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] TOP_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd1;

    logic [31:0] mem [DEPTH_WORDS];

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end

    rsp_fsm_e        state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic            err_q, err_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    axi_resp_e       rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic [ID_W-1:0] rid_q, rid_d;

    logic [15:0]     lfsr_q;
    logic            unused_lfsr;
    logic [3:0]      lat_sel;
    logic            start;
    logic            load;
    logic [31:0]     off;
    logic [AW-1:0]   idx;

    ysyx_24080006_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:2];
    assign lat_sel     = (LAT_MODE == 1) ? {2'b00, lfsr_q[1:0]} : 4'(FIXED_LAT);

    // Response registers are always filled from the *_d beat context, so the
    // zero-wait path (straight to RESP) and the DELAY exit share one loader.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        rid_d   = rid_q;
        start   = 1'b0;
        load    = 1'b0;
        off     = '0;
        idx     = '0;

        unique case (state_q)
            IDLE: begin
                if (arvalid) begin
                    addr_d = araddr;
                    id_d   = arid;
                    len_d  = arlen;
                    beat_d = 8'd0;
                    err_d  = (arsize != 3'b010) || (arburst != INCR) || (araddr[1:0] != 2'b00);
                    start  = 1'b1;
                end
            end
            DELAY: begin
                if (cnt_q == 4'd1) begin
                    load    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + 32'd4;
                        beat_d = beat_q + 8'd1;
                        start  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            cnt_d = lat_sel;
            if (lat_sel == 4'd0) begin
                load    = 1'b1;
                state_d = RESP;
            end else begin
                state_d = DELAY;
            end
        end

        if (load) begin
            off     = addr_d - BASE_ADDR;
            idx     = AW'(off >> 2);
            rlast_d = (beat_d == len_d);
            rid_d   = id_d;
            if (err_d) begin
                rresp_d = SLVERR;
                rdata_d = '0;
            end else if ((addr_d < BASE_ADDR) || (addr_d > TOP_ADDR)) begin
                rresp_d = DECERR;
                rdata_d = '0;
            end else begin
                rresp_d = OKAY;
                rdata_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rresp_q <= OKAY;
            rlast_q <= 1'b0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
            rid_q   <= rid_d;
        end
    end

    assign arready = (state_q == IDLE);
    assign rvalid  = (state_q == RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

endmodule

// File: tb/tb_ysyx_24080006_axi_rom_slv.sv
// tb/tb_ysyx_24080006_axi_rom_slv.sv - directed and randomized bench for the AXI ROM responder
module tb_ysyx_24080006_axi_rom_slv;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;

    logic        arready0, rvalid0, rlast0, arready1, rvalid1, rlast1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  rresp0, rresp1;
    logic [3:0]  rid0, rid1;

    logic        arready_m, rvalid_m, rlast_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m;
    logic [3:0]  rid_m;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [15:0] m_lfsr;
    bit          seen [5];

    always #5 clock = ~clock;

    // Reference sequence of the latency source, advanced once per cycle out of reset
    always @(posedge clock) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    ysyx_24080006_axi_rom_slv #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE(""), .LAT_MODE(0),
        .FIXED_LAT(1), .LFSR_SEED(SEED), .ID_W(4)
    ) dut0 (
        .clock(clock), .reset(reset), .arvalid(arvalid & ~sel), .arready(arready0),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid0), .rready(rready), .rdata(rdata0), .rresp(rresp0),
        .rlast(rlast0), .rid(rid0)
    );

    ysyx_24080006_axi_rom_slv #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE(""), .LAT_MODE(1),
        .FIXED_LAT(1), .LFSR_SEED(SEED), .ID_W(4)
    ) dut1 (
        .clock(clock), .reset(reset), .arvalid(arvalid & sel), .arready(arready1),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid1), .rready(rready), .rdata(rdata1), .rresp(rresp1),
        .rlast(rlast1), .rid(rid1)
    );

    assign arready_m = sel ? arready1 : arready0;
    assign rvalid_m  = sel ? rvalid1  : rvalid0;
    assign rlast_m   = sel ? rlast1   : rlast0;
    assign rdata_m   = sel ? rdata1   : rdata0;
    assign rresp_m   = sel ? rresp1   : rresp0;
    assign rid_m     = sel ? rid1     : rid0;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {rresp, rdata} the memory must return for one beat
    function automatic logic [33:0] model_beat(input logic [31:0] a, input bit err);
        logic [31:0] o;
        o = a - BASE;
        if (err) return {2'b10, 32'h0};
        if (a < BASE || a > BASE + 32'(4 * DEPTH) - 32'd1) return {2'b11, 32'h0};
        return {2'b00, model_mem[o[13:2]]};
    endfunction

    task automatic check_beat(input logic [33:0] e, input bit last, input logic [3:0] id);
        check("rvalid", 32'(rvalid_m), 32'd1);
        check("rdata", rdata_m, e[31:0]);
        check("rresp", 32'(rresp_m), 32'(e[33:32]));
        check("rlast", 32'(rlast_m), 32'(last));
        check("rid", 32'(rid_m), 32'(id));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int hold);
        bit          err;
        int          w;
        int          lat;
        logic [33:0] e;
        err     = (size != 3'd2) || (burst != 2'd1) || (a[1:0] != 2'd0);
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        rready  = (hold == 0);
        w = 0;
        while (!arready_m && w < 50) begin tick(); w++; end
        check("ar_accept_in_time", 32'(w < 50), 32'd1);
        tick();
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            lat = 1;
            while (!rvalid_m && lat < 50) begin
                check("busy_arready", 32'(arready_m), 32'd0);
                tick();
                lat++;
            end
            check("beat_latency", 32'(lat), 32'd2);
            e = model_beat(a + 32'(4 * b), err);
            check_beat(e, b == int'(len), id);
            for (int h = 0; h < hold; h++) begin
                tick();
                check_beat(e, b == int'(len), id);
            end
            rready = 1'b1;
            tick();
            if (hold != 0 && b != int'(len)) rready = 1'b0;
        end
        check("after_last_rvalid", 32'(rvalid_m), 32'd0);
        check("after_last_arready", 32'(arready_m), 32'd1);
    endtask

    task automatic rand_req();
        int k;
        k = int'($urandom_range(0, 15));
        if (k == 0)      araddr = 32'h1000_0000 + 32'(4 * $urandom_range(0, 1023));
        else if (k == 1) araddr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'd2;
        else             araddr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        arid    = 4'($urandom_range(0, 15));
        arlen   = 8'd0;
        arsize  = 3'd2;
        arburst = 2'd1;
        arvalid = 1'b1;
    endtask

    initial begin
        int          w, lat, n;
        bit          r;
        logic [31:0] ca;
        logic [3:0]  cid;
        bit          cerr;
        logic [1:0]  exp_d;
        logic [33:0] e;

        reset = 1'b1; sel = 1'b0; arvalid = 1'b0; araddr = '0; arid = '0;
        arlen = '0; arsize = 3'd2; arburst = 2'd1; rready = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = $urandom;
        model_mem[0] = 32'h0000_0413;
        for (int i = 0; i < DEPTH; i++) begin
            dut0.mem[i] = model_mem[i];
            dut1.mem[i] = model_mem[i];
        end
        @(negedge clock);
        tick(); tick();
        reset = 1'b0;

        check("reset_arready", 32'(arready0), 32'd1);
        check("reset_rvalid", 32'(rvalid0), 32'd0);
        check("reset_rdata", rdata0, 32'd0);
        check("reset_rresp", 32'(rresp0), 32'd0);
        check("reset_rlast", 32'(rlast0), 32'd0);
        check("reset_rid", 32'(rid0), 32'd0);
        check("reset_rvalid1", 32'(rvalid1), 32'd0);
        check("reset_arready1", 32'(arready1), 32'd1);

        do_read(32'h8000_0000, 4'd5, 8'd0, 3'd2, 2'd1, 0);
        do_read(32'h8000_0000, 4'd6, 8'd0, 3'd2, 2'd1, 5);
        do_read(32'h8000_3FF8, 4'd9, 8'd3, 3'd2, 2'd1, 0);
        do_read(32'h8000_0100, 4'd3, 8'd2, 3'd2, 2'd1, 2);
        do_read(32'h8000_0002, 4'd1, 8'd0, 3'd2, 2'd1, 0);
        do_read(32'h8000_0010, 4'd2, 8'd0, 3'd3, 2'd1, 0);
        do_read(32'h8000_0010, 4'd4, 8'd0, 3'd2, 2'd0, 1);
        do_read(32'h0000_1000, 4'd7, 8'd0, 3'd2, 2'd1, 0);
        do_read(32'hFFFF_FFFC, 4'd8, 8'd1, 3'd2, 2'd1, 0);

        // Reset while a beat is being held in RESP
        arvalid = 1'b1; araddr = 32'h8000_0040; arid = 4'hA; arlen = 8'd1;
        arsize = 3'd2; arburst = 2'd1; rready = 1'b0;
        w = 0;
        while (!arready0 && w < 50) begin tick(); w++; end
        tick();
        arvalid = 1'b0;
        w = 0;
        while (!rvalid0 && w < 50) begin tick(); w++; end
        check("pre_reset_rvalid", 32'(rvalid0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_reset_rvalid", 32'(rvalid0), 32'd0);
        check("post_reset_arready", 32'(arready0), 32'd1);
        check("post_reset_rdata", rdata0, 32'd0);
        check("post_reset_rlast", 32'(rlast0), 32'd0);
        tick();
        check("no_replay_rvalid", 32'(rvalid0), 32'd0);
        do_read(32'h8000_0044, 4'hB, 8'd0, 3'd2, 2'd1, 0);

        // Random latency, random rready, next AR presented while busy
        sel = 1'b1;
        rready = 1'b0;
        arvalid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!arvalid) rand_req();
            w = 0;
            while (!arready_m && w < 50) begin
                check("ar_r_exclusive", 32'(arready_m & rvalid_m), 32'd0);
                rready = 1'($urandom_range(0, 1));
                tick();
                w++;
            end
            check("rand_ar_in_time", 32'(w < 50), 32'd1);
            ca = araddr; cid = arid; cerr = (araddr[1:0] != 2'd0); exp_d = m_lfsr[1:0];
            tick();
            if (i < 199 && $urandom_range(0, 1) == 1) rand_req();
            else arvalid = 1'b0;
            lat = 1;
            while (!rvalid_m && lat < 50) begin
                check("rand_busy_arready", 32'(arready_m), 32'd0);
                rready = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            check("rand_latency", 32'(lat), 32'(1 + exp_d));
            if (lat >= 1 && lat <= 4) seen[lat] = 1'b1;
            e = model_beat(ca, cerr);
            check_beat(e, 1'b1, cid);
            check("rand_ar_r_exclusive", 32'(arready_m & rvalid_m), 32'd0);
            n = 0;
            do begin
                r = 1'($urandom_range(0, 1));
                rready = r;
                tick();
                n++;
                if (!r) check_beat(e, 1'b1, cid);
            end while (!r && n < 50);
            check("rand_done_rvalid", 32'(rvalid_m), 32'd0);
            check("rand_done_arready", 32'(arready_m), 32'd1);
        end
        for (int k = 1; k <= 4; k++) check("latency_seen", 32'(seen[k]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
